// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and default sizing for the pipeline control unit
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_ONE  = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 32;
endpackage

// File: rtl/pipeline_control_unit_hazard.sv
// hazard_detection_unit: load-use compare between the load in EX and the sources in ID
module hazard_detection_unit #(
  parameter int BUS_REG = 5
) (
  input  logic [BUS_REG-1:0] i_id_rs,
  input  logic [BUS_REG-1:0] i_id_rt,
  input  logic [BUS_REG-1:0] i_ex_rt,
  input  logic               i_ex_mem_read,
  output logic               o_stall
);
  always_comb o_stall = i_ex_mem_read && (i_ex_rt != '0) && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: run/step/halt FSM sequencing PC and latch enables/flushes; PIPE_CTRL_STALL_CNT_EN adds o_stall_count
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_REG      = 5,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_mode_step,
  input  logic               i_step,
  input  logic               i_halt_instr,
  input  logic               i_branch_taken,
  input  logic [BUS_REG-1:0] i_id_rs,
  input  logic [BUS_REG-1:0] i_id_rt,
  input  logic [BUS_REG-1:0] i_ex_rt,
  input  logic               i_ex_mem_read,
  output logic               o_pc_enable,
  output logic               o_ifid_enable,
  output logic               o_idex_enable,
  output logic               o_exmem_enable,
  output logic               o_memwb_enable,
  output logic               o_ifid_flush,
  output logic               o_idex_flush,
  output logic               o_halted,
  output logic [2:0]         o_state,
  output logic [CNT_W-1:0]   o_cycle_count
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   o_stall_count
`endif
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             hz, act, adv, stall, go;
  hazard_detection_unit #(.BUS_REG(BUS_REG)) u_hdu (
    .i_id_rs(i_id_rs),
    .i_id_rt(i_id_rt),
    .i_ex_rt(i_ex_rt),
    .i_ex_mem_read(i_ex_mem_read),
    .o_stall(hz)
  );
  always_comb begin
    act            = state_q == S_RUN || state_q == S_STEP_ONE;
    adv            = act || state_q == S_DRAIN;
    stall          = act && hz;
    go             = act && !stall;
    o_pc_enable    = go;
    o_ifid_enable  = go;
    o_idex_enable  = adv;
    o_exmem_enable = adv;
    o_memwb_enable = adv;
    o_ifid_flush   = go && !i_halt_instr && i_branch_taken;
    o_idex_flush   = stall || state_q == S_DRAIN;
    o_halted       = state_q == S_HALTED;
    o_state        = state_q;
    o_cycle_count  = cyc_q;
    cyc_d          = (adv && !(&cyc_q)) ? cyc_q + CNT_W'(1) : cyc_q;
    state_d        = state_q;
    drain_d        = drain_q;
    case (state_q)
      S_IDLE:      state_d = i_run ? (i_mode_step ? S_STEP_WAIT : S_RUN) : S_IDLE;
      S_RUN:       state_d = (go && i_halt_instr) ? S_DRAIN : S_RUN;
      S_STEP_WAIT: state_d = i_step ? S_STEP_ONE : S_STEP_WAIT;
      S_STEP_ONE:  state_d = (go && i_halt_instr) ? S_DRAIN : S_STEP_WAIT;
      S_DRAIN:     state_d = (drain_q == '0) ? S_HALTED : S_DRAIN;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
    if (go && i_halt_instr) drain_d = DW'(DRAIN_CYCLES - 1);
    else if (state_q == S_DRAIN && drain_q != '0) drain_d = drain_q - DW'(1);
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
    end
  end
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stc_q, stc_d;
  always_comb begin
    stc_d         = (stall && !(&stc_q)) ? stc_q + CNT_W'(1) : stc_q;
    o_stall_count = stc_q;
  end
  always_ff @(posedge i_clock) stc_q <= i_reset ? '0 : stc_d;
`endif
endmodule
